// File: rtl/vga_pkg.sv
// vga_pkg: shared levels, colour constants and pattern codes for the VGA pattern source
package vga_pkg;

    localparam logic [7:0] BLACK_LVL = 8'd9;
    localparam logic [7:0] LVL_75    = 8'd192;
    localparam logic [7:0] LVL_100   = 8'd255;
    localparam logic [7:0] CHK_DARK  = 8'd64;

    localparam logic [7:0] IRE_LVL [11] = '{
        8'd0, 8'd26, 8'd51, 8'd77, 8'd102, 8'd128,
        8'd153, 8'd178, 8'd204, 8'd229, 8'd255
    };

    localparam logic [23:0] WHT_75 = {LVL_75, LVL_75, LVL_75};
    localparam logic [23:0] YEL_75 = {LVL_75, LVL_75, BLACK_LVL};
    localparam logic [23:0] CYN_75 = {BLACK_LVL, LVL_75, LVL_75};
    localparam logic [23:0] GRN_75 = {BLACK_LVL, LVL_75, BLACK_LVL};
    localparam logic [23:0] MAG_75 = {LVL_75, BLACK_LVL, LVL_75};
    localparam logic [23:0] RED_75 = {LVL_75, BLACK_LVL, BLACK_LVL};
    localparam logic [23:0] BLU_75 = {BLACK_LVL, BLACK_LVL, LVL_75};
    localparam logic [23:0] BLK_75 = {BLACK_LVL, BLACK_LVL, BLACK_LVL};

    localparam logic [23:0] RED_100 = {LVL_100, 8'd0, 8'd0};
    localparam logic [23:0] GRN_100 = {8'd0, LVL_100, 8'd0};
    localparam logic [23:0] BLU_100 = {8'd0, 8'd0, LVL_100};
    localparam logic [23:0] WHT_100 = {LVL_100, LVL_100, LVL_100};

    // bar order left to right
    localparam logic [23:0] BAR_RGB [8] = '{
        WHT_75, YEL_75, CYN_75, GRN_75, MAG_75, RED_75, BLU_75, BLK_75
    };

    localparam logic [3:0] PAT_IRE0  = 4'd0;
    localparam logic [3:0] PAT_IRE1  = 4'd1;
    localparam logic [3:0] PAT_IRE2  = 4'd2;
    localparam logic [3:0] PAT_IRE3  = 4'd3;
    localparam logic [3:0] PAT_IRE4  = 4'd4;
    localparam logic [3:0] PAT_IRE5  = 4'd5;
    localparam logic [3:0] PAT_IRE6  = 4'd6;
    localparam logic [3:0] PAT_IRE7  = 4'd7;
    localparam logic [3:0] PAT_IRE8  = 4'd8;
    localparam logic [3:0] PAT_IRE9  = 4'd9;
    localparam logic [3:0] PAT_IRE10 = 4'd10;
    localparam logic [3:0] PAT_RED   = 4'd11;
    localparam logic [3:0] PAT_GRN   = 4'd12;
    localparam logic [3:0] PAT_BLU   = 4'd13;
    localparam logic [3:0] PAT_BARS  = 4'd14;
    localparam logic [3:0] PAT_BOX   = 4'd15;

    function automatic logic [23:0] grey(input logic [7:0] lvl);
        return {lvl, lvl, lvl};
    endfunction

endpackage

// File: rtl/vga_if.sv
// vga_if: pattern request in, sync/blank/DE/position/RGB out
interface vga_if #(parameter int CW = 12);

    logic [3:0]    patt_select;
    logic          hs;
    logic          vs;
    logic [7:0]    vga_r;
    logic [7:0]    vga_g;
    logic [7:0]    vga_b;
    logic          vga_de;
    logic          hblank;
    logic          vblank;
    logic          frame_start;
    logic [CW-1:0] h_pos;
    logic [CW-1:0] v_pos;

    modport master (
        input  patt_select,
        output hs, vs, vga_r, vga_g, vga_b, vga_de, hblank, vblank, frame_start, h_pos, v_pos
    );

    modport slave (
        output patt_select,
        input  hs, vs, vga_r, vga_g, vga_b, vga_de, hblank, vblank, frame_start, h_pos, v_pos
    );

endinterface

// File: rtl/vga_timing.sv
// vga_timing: raster counters plus registered sync, blanking, DE and position
module vga_timing #(
    parameter int H      = 336,
    parameter int HFP    = 27,
    parameter int HS     = 10,
    parameter int HBP    = 55,
    parameter int V      = 240,
    parameter int VFP    = 5,
    parameter int VS     = 4,
    parameter int VBP    = 20,
    parameter bit HS_POL = 1'b0,
    parameter bit VS_POL = 1'b1,
    parameter int CW     = 12
) (
    input  logic          pclk,
    input  logic          reset_n,
    output logic [CW-1:0] h_cnt,
    output logic [CW-1:0] v_cnt,
    output logic          h_end,
    output logic          frame_end,
    output logic          active,
    output logic          hs,
    output logic          vs,
    output logic          hblank,
    output logic          vblank,
    output logic          de,
    output logic          frame_start,
    output logic [CW-1:0] h_pos,
    output logic [CW-1:0] v_pos
);

    localparam logic [CW-1:0] H_C   = CW'(H);
    localparam logic [CW-1:0] HS_B  = CW'(H + HFP);
    localparam logic [CW-1:0] HS_E  = CW'(H + HFP + HS);
    localparam logic [CW-1:0] H_MAX = CW'(H + HFP + HS + HBP - 1);
    localparam logic [CW-1:0] V_C   = CW'(V);
    localparam logic [CW-1:0] VS_B  = CW'(V + VFP);
    localparam logic [CW-1:0] VS_E  = CW'(V + VFP + VS);
    localparam logic [CW-1:0] V_MAX = CW'(V + VFP + VS + VBP - 1);

    if (H + HFP + HS + HBP >= 2 ** CW || V + VFP + VS + VBP >= 2 ** CW) begin : g_cw_chk
        $error("vga_timing: line or frame total does not fit in CW bits");
    end

    assign h_end     = h_cnt == H_MAX;
    assign frame_end = h_end && v_cnt == V_MAX;
    assign active    = h_cnt < H_C && v_cnt < V_C;

    // raster counters; v advances only on line wrap
    always_ff @(posedge pclk) begin
        if (!reset_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            h_cnt <= h_end ? '0 : h_cnt + 1'b1;
            if (h_end)
                v_cnt <= v_cnt == V_MAX ? '0 : v_cnt + 1'b1;
        end
    end

    // one-cycle registered view of the current counter position
    always_ff @(posedge pclk) begin
        if (!reset_n) begin
            hs          <= !HS_POL;
            vs          <= !VS_POL;
            hblank      <= 1'b1;
            vblank      <= 1'b1;
            de          <= 1'b0;
            frame_start <= 1'b0;
            h_pos       <= '0;
            v_pos       <= '0;
        end else begin
            hs          <= (h_cnt >= HS_B && h_cnt < HS_E) ? HS_POL : !HS_POL;
            vs          <= (v_cnt >= VS_B && v_cnt < VS_E) ? VS_POL : !VS_POL;
            hblank      <= h_cnt >= H_C;
            vblank      <= v_cnt >= V_C;
            de          <= active;
            frame_start <= h_cnt == '0 && v_cnt == '0;
            h_pos       <= h_cnt;
            v_pos       <= v_cnt;
        end
    end

endmodule

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: programmable VGA source with grey, primary, bar and bouncing-box patterns
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int H         = 336,
    parameter int HFP       = 27,
    parameter int HS        = 10,
    parameter int HBP       = 55,
    parameter int V         = 240,
    parameter int VFP       = 5,
    parameter int VS        = 4,
    parameter int VBP       = 20,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b1,
    parameter int CW        = 12,
    parameter int CHK_SHIFT = 3,
    parameter int BOX_SIZE  = 16
) (
    input  logic  pclk,
    input  logic  reset_n,
    vga_if.master vid
);

    localparam logic [CW-1:0] H_C      = CW'(H);
    localparam logic [CW-1:0] V_C      = CW'(V);
    localparam logic [CW-1:0] BOX_C    = CW'(BOX_SIZE);
    localparam logic [CW-1:0] BAR_LAST = CW'(H / 8 - 1);

    if (H < 8 || BOX_SIZE >= H || BOX_SIZE >= V || CHK_SHIFT >= CW) begin : g_par_chk
        $error("vga_pattern_gen: H, BOX_SIZE or CHK_SHIFT out of range");
    end

    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;
    logic [CW-1:0] box_x;
    logic [CW-1:0] box_y;
    logic [CW-1:0] bar_sub;
    logic [3:0]    bar_idx;
    logic [3:0]    patt_q;
    logic          h_end;
    logic          frame_end;
    logic          active;
    logic          dx_pos;
    logic          dy_pos;
    logic          dx_nxt;
    logic          dy_nxt;
    logic          in_box;
    logic [23:0]   rgb;

    vga_timing #(
        .H(H), .HFP(HFP), .HS(HS), .HBP(HBP),
        .V(V), .VFP(VFP), .VS(VS), .VBP(VBP),
        .HS_POL(HS_POL), .VS_POL(VS_POL), .CW(CW)
    ) u_timing (
        .pclk        (pclk),
        .reset_n     (reset_n),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .h_end       (h_end),
        .frame_end   (frame_end),
        .active      (active),
        .hs          (vid.hs),
        .vs          (vid.vs),
        .hblank      (vid.hblank),
        .vblank      (vid.vblank),
        .de          (vid.vga_de),
        .frame_start (vid.frame_start),
        .h_pos       (vid.h_pos),
        .v_pos       (vid.v_pos)
    );

    // the bounce decision is applied in the same update that moves the box
    assign dx_nxt = dx_pos ? (box_x + BOX_C < H_C) : (box_x == '0);
    assign dy_nxt = dy_pos ? (box_y + BOX_C < V_C) : (box_y == '0);
    assign in_box = h_cnt >= box_x && h_cnt < box_x + BOX_C
                 && v_cnt >= box_y && v_cnt < box_y + BOX_C;

    // pattern latch and box motion, only at the frame boundary so a frame never tears
    always_ff @(posedge pclk) begin
        if (!reset_n) begin
            patt_q <= PAT_IRE0;
            box_x  <= '0;
            box_y  <= '0;
            dx_pos <= 1'b1;
            dy_pos <= 1'b1;
        end else if (frame_end) begin
            patt_q <= vid.patt_select;
            dx_pos <= dx_nxt;
            dy_pos <= dy_nxt;
            box_x  <= dx_nxt ? box_x + 1'b1 : box_x - 1'b1;
            box_y  <= dy_nxt ? box_y + 1'b1 : box_y - 1'b1;
        end
    end

    // bar index tracks h_cnt; it saturates at 8, which marks the black tail past the last bar
    always_ff @(posedge pclk) begin
        if (!reset_n || h_end) begin
            bar_idx <= '0;
            bar_sub <= '0;
        end else if (bar_sub == BAR_LAST) begin
            bar_sub <= '0;
            bar_idx <= bar_idx + {3'b000, !bar_idx[3]};
        end else begin
            bar_sub <= bar_sub + 1'b1;
        end
    end

    // colour for the current counter position
    always_comb begin
        rgb = '0;
        case (patt_q)
            PAT_IRE0, PAT_IRE1, PAT_IRE2, PAT_IRE3, PAT_IRE4, PAT_IRE5,
            PAT_IRE6, PAT_IRE7, PAT_IRE8, PAT_IRE9, PAT_IRE10:
                rgb = grey(IRE_LVL[patt_q]);
            PAT_RED:  rgb = RED_100;
            PAT_GRN:  rgb = GRN_100;
            PAT_BLU:  rgb = BLU_100;
            PAT_BARS: rgb = bar_idx[3] ? BLK_75 : BAR_RGB[bar_idx[2:0]];
            PAT_BOX:  rgb = in_box ? WHT_100
                          : grey((h_cnt[CHK_SHIFT] ^ v_cnt[CHK_SHIFT]) ? CHK_DARK : LVL_75);
        endcase
    end

    // registered RGB, forced black outside the active area
    always_ff @(posedge pclk) begin
        if (!reset_n)
            {vid.vga_r, vid.vga_g, vid.vga_b} <= '0;
        else
            {vid.vga_r, vid.vga_g, vid.vga_b} <= active ? rgb : '0;
    end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb_vga_pattern_gen: directed checks of timing, pattern latching, bars, box bounce and reset
module tb_vga_pattern_gen;

    // reduced raster so many frames fit in a short run
    localparam int H = 44, HFP = 2, HS = 3, HBP = 3;
    localparam int V = 20, VFP = 1, VS = 2, VBP = 2;
    localparam int HT = 52, VT = 25, FRAME = HT * VT;

    logic pclk = 1'b0;
    logic reset_n = 1'b0;

    vga_if #(.CW(12)) vid ();

    vga_pattern_gen #(
        .H(H), .HFP(HFP), .HS(HS), .HBP(HBP),
        .V(V), .VFP(VFP), .VS(VS), .VBP(VBP),
        .HS_POL(1'b0), .VS_POL(1'b1), .CW(12), .CHK_SHIFT(3), .BOX_SIZE(16)
    ) dut (
        .pclk    (pclk),
        .reset_n (reset_n),
        .vid     (vid)
    );

    always #5 pclk = ~pclk;

    int checks = 0;
    int errors = 0;
    logic [23:0] fb [HT][VT];
    int period, hs_low, hs_first, vs_hi, vs_first, de_cnt, tim_bad, blank_bad;
    int ytab [8] = '{0, 1, 2, 3, 4, 3, 2, 1};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    function automatic logic [23:0] pix();
        return {vid.vga_r, vid.vga_g, vid.vga_b};
    endfunction

    function automatic logic [23:0] chk_rgb(input int x, input int y);
        return (x[3] ^ y[3]) ? 24'h404040 : 24'hC0C0C0;
    endfunction

    function automatic int count_val(input logic [23:0] val);
        int c = 0;
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++)
                c += int'(fb[x][y] == val);
        return c;
    endfunction

    // walks one frame starting on a frame_start sample, gathering timing statistics
    task automatic run_frame(input int chg_at, input logic [3:0] sel);
        int n = 0;
        int h, v;
        hs_low = 0; hs_first = -1; vs_hi = 0; vs_first = -1;
        de_cnt = 0; tim_bad = 0; blank_bad = 0;
        do begin
            if (n == chg_at) vid.patt_select = sel;
            h = int'(vid.h_pos);
            v = int'(vid.v_pos);
            if (h < HT && v < VT) fb[h][v] = pix();
            if (v == 0 && !vid.hs) begin
                if (hs_first < 0) hs_first = h;
                hs_low++;
            end
            if (vid.vs) begin
                if (vs_first < 0) vs_first = v;
                vs_hi++;
            end
            de_cnt += int'(vid.vga_de);
            if (h != n % HT || v != n / HT || vid.vga_de !== (h < H && v < V)
                || vid.hblank !== (h >= H) || vid.vblank !== (v >= V)) tim_bad++;
            if (!vid.vga_de && pix() != 24'h0) blank_bad++;
            tick();
            n++;
        end while (!vid.frame_start && n < 2 * FRAME);
        period = n;
    endtask

    initial begin
        int bx, by;
        bit found;
        vid.patt_select = 4'd0;
        repeat (3) tick();
        check("rst_de", vid.vga_de, 0);
        check("rst_fs", vid.frame_start, 0);
        check("rst_hblank", vid.hblank, 1);
        check("rst_vblank", vid.vblank, 1);
        check("rst_hs", vid.hs, 1);
        check("rst_vs", vid.vs, 0);
        check("rst_hpos", vid.h_pos, 0);
        check("rst_rgb", pix(), 0);
        reset_n = 1'b1;
        tick();
        check("rel_fs", vid.frame_start, 1);
        check("rel_pos", {vid.h_pos, vid.v_pos}, 0);
        // frame 1: pattern 0, request 5 mid-frame
        run_frame(600, 4'd5);
        check("f1_period", period, FRAME);
        check("hs_low_cnt", hs_low, 3);
        check("hs_first", hs_first, 46);
        check("vs_hi_cnt", vs_hi, 104);
        check("vs_first", vs_first, 21);
        check("de_cnt", de_cnt, 880);
        check("f1_timing", tim_bad, 0);
        check("f1_black", count_val(24'h000000), 880);
        check("f1_fs", vid.frame_start, 1);
        // frame 2: IRE step 5, request bars mid-frame
        run_frame(600, 4'd14);
        check("f2_period", period, FRAME);
        check("f2_grey128", count_val(24'h808080), 880);
        check("f2_blank", blank_bad, 0);
        // frame 3: colour bars, bar width 5
        run_frame(600, 4'd15);
        check("bar_x4", fb[4][0], 24'hC0C0C0);
        check("bar_x5", fb[5][0], 24'hC0C009);
        check("bar_x10", fb[10][3], 24'h09C0C0);
        check("bar_x15", fb[15][3], 24'h09C009);
        check("bar_x20", fb[20][7], 24'hC009C0);
        check("bar_x25", fb[25][19], 24'hC00909);
        check("bar_x34", fb[34][0], 24'h0909C0);
        check("bar_x35", fb[35][0], 24'h090909);
        check("bar_x40", fb[40][0], 24'h090909);
        check("bar_x43", fb[43][19], 24'h090909);
        check("f3_blank", blank_bad, 0);
        // box frames: k boundaries since reset; x peaks at 28, y bounces between 0 and 4
        for (int k = 3; k <= 30; k++) begin
            run_frame(-1, 4'd15);
            bx = k <= 28 ? k : 56 - k;
            by = ytab[k % 8];
            check($sformatf("box_in_k%0d", k), fb[bx][by], 24'hFFFFFF);
            check($sformatf("box_left_k%0d", k), fb[bx - 1][by], chk_rgb(bx - 1, by));
            if (k == 3) begin
                check("box_far", fb[18][18], 24'hFFFFFF);
                check("box_right", fb[19][18], 24'hC0C0C0);
                check("chk_origin", fb[0][0], 24'hC0C0C0);
                check("chk_dark", fb[12][2], 24'h404040);
                check("f4_blank", blank_bad, 0);
            end
        end
        // mid-line reset at output (20,10)
        found = 1'b0;
        for (int i = 0; i < FRAME && !found; i++) begin
            if (vid.h_pos == 12'd20 && vid.v_pos == 12'd10) found = 1'b1;
            else tick();
        end
        check("find_20_10", found, 1);
        reset_n = 1'b0;
        tick();
        check("mrst_pos", {vid.h_pos, vid.v_pos}, 0);
        check("mrst_fs", vid.frame_start, 0);
        check("mrst_de", vid.vga_de, 0);
        check("mrst_rgb", pix(), 0);
        reset_n = 1'b1;
        tick();
        check("mrel_fs", vid.frame_start, 1);
        check("mrel_pos", {vid.h_pos, vid.v_pos}, 0);
        check("mrel_de", vid.vga_de, 1);
        check("mrel_rgb", pix(), 0);
        run_frame(-1, 4'd15);
        check("mrel_period", period, FRAME);
        check("mrel_black", count_val(24'h000000), 880);
        run_frame(-1, 4'd15);
        check("mrel_box11", fb[1][1], 24'hFFFFFF);
        check("mrel_left", fb[0][1], 24'hC0C0C0);
        check("mrel_box_end", fb[16][16], 24'hFFFFFF);
        check("mrel_outside", fb[17][16], 24'hC0C0C0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
